// File: rtl/rx_delay_line_pkg.sv
// Shared types, default constants and the delay clamp for rx_delay_line.
package rx_delay_line_pkg;

    localparam int DEF_WIDTH     = 1;
    localparam int DEF_LANES     = 4;
    localparam int DEF_MAX_DEPTH = 8;
    localparam int DEF_DW        = 4;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // 0 means "as short as possible" (1 clock); anything past the pipe length saturates.
    function automatic int unsigned clamp_delay(input int unsigned raw,
                                                input int unsigned max_depth);
        int unsigned d;
        d = raw;
        if (raw == 0) begin
            d = 1;
        end else if (raw > max_depth) begin
            d = max_depth;
        end
        return d;
    endfunction

endpackage

// File: rtl/rx_delay_line_lane.sv
// One lane of rx_delay_line: the first MAX_DEPTH-1 delay stages plus the tap mux.
// The top's output register is the final stage, so tap index delay-2 gives exact latency.
module rx_delay_lane
    import rx_delay_line_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int DW        = DEF_DW
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic             clear,
    input  logic [DW-1:0]    delay,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] tap_data,
    output logic             tap_valid
);

    localparam int STAGES = MAX_DEPTH - 1;

    logic [WIDTH-1:0]  sr_data [STAGES];
    logic [STAGES-1:0] sr_valid;

    // NOTE: these stages are reset and cleared on purpose, since stale payload must never
    // reach data_out; that keeps them out of RAM inference, which is fine at this depth.
    always_ff @(posedge clk_8f) begin
        if (!reset || clear) begin
            sr_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sr_data[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
            sr_valid[0] <= valid_in;
            sr_data[0]  <= valid_in ? data_in : '0;
            for (int i = 1; i < STAGES; i++) begin
                sr_valid[i] <= sr_valid[i-1];
                sr_data[i]  <= sr_data[i-1];
            end
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through this block can infer a latch.
        tap_valid = valid_in;
        tap_data  = data_in;
        for (int i = 0; i < STAGES; i++) begin
            if (delay == DW'(i + 2)) begin
                tap_valid = sr_valid[i];
                tap_data  = sr_data[i];
            end
        end
    end

endmodule

// File: rtl/rx_delay_line.sv
// Multi-lane programmable delay line with a RUN/FLUSH refill controller.
// Optional `aligned` output is built when RX_DELAY_ALIGN_FLAG_EN is defined.
module rx_delay_line
    import rx_delay_line_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LANES     = DEF_LANES,
    parameter int MAX_DEPTH = DEF_MAX_DEPTH,
    parameter int DW        = DEF_DW
) (
    input  logic                   clk_8f,
    input  logic                   reset,
    input  logic [LANES*WIDTH-1:0] data_in,
    input  logic [LANES-1:0]       valid_in,
    input  logic [LANES*DW-1:0]    delay_cfg,
    input  logic                   cfg_load,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   busy
`ifdef RX_DELAY_ALIGN_FLAG_EN
    ,
    output logic                   aligned
`endif
);

    state_t                 state, state_next;
    logic [DW-1:0]          cnt, cnt_next, max_d;
    logic [DW-1:0]          delay_q   [LANES];
    logic [DW-1:0]          delay_new [LANES];
    logic [LANES-1:0]       tap_valid, valid_next;
    logic [LANES*WIDTH-1:0] tap_data, data_next;

    always_comb begin
        max_d = '0;
        for (int n = 0; n < LANES; n++) begin
            delay_new[n] = DW'(clamp_delay(32'(delay_cfg[n*DW +: DW]), MAX_DEPTH));
            if (delay_new[n] > max_d) begin
                max_d = delay_new[n];
            end
        end
    end

    // A load (in either state) restarts the refill window from the longest new delay.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (cfg_load) begin
            state_next = FLUSH;
            cnt_next   = max_d;
        end else if (state == FLUSH) begin
            cnt_next = cnt - DW'(1);
            if (cnt_next == '0) begin
                state_next = RUN;
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
            for (int n = 0; n < LANES; n++) begin
                delay_q[n] <= DW'(MAX_DEPTH);
            end
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (cfg_load) begin
                for (int n = 0; n < LANES; n++) begin
                    delay_q[n] <= delay_new[n];
                end
            end
        end
    end

    assign busy = (state == FLUSH);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        rx_delay_lane #(
            .WIDTH     (WIDTH),
            .MAX_DEPTH (MAX_DEPTH),
            .DW        (DW)
        ) u_lane (
            .clk_8f    (clk_8f),
            .reset     (reset),
            .clear     (cfg_load),
            .delay     (delay_q[n]),
            .data_in   (data_in[n*WIDTH +: WIDTH]),
            .valid_in  (valid_in[n]),
            .tap_data  (tap_data[n*WIDTH +: WIDTH]),
            .tap_valid (tap_valid[n])
        );
    end

    always_comb begin
        valid_next = '0;
        data_next  = '0;
        for (int n = 0; n < LANES; n++) begin
            valid_next[n] = tap_valid[n] && !cfg_load;
            if (valid_next[n]) begin
                data_next[n*WIDTH +: WIDTH] = tap_data[n*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            valid_out <= '0;
            data_out  <= '0;
        end else begin
            valid_out <= valid_next;
            data_out  <= data_next;
        end
    end

`ifdef RX_DELAY_ALIGN_FLAG_EN
    // Built from next-state values so the flag lines up with the outputs it describes.
    always_ff @(posedge clk_8f) begin
        if (!reset) begin
            aligned <= 1'b0;
        end else begin
            aligned <= (&valid_next) && (state_next == RUN);
        end
    end
`endif

endmodule

// File: tb/tb_rx_delay_line.sv
// Self-checking bench for rx_delay_line: per-cycle scoreboard plus latency vector table.
module tb_rx_delay_line;

    localparam int WIDTH     = 4;
    localparam int LANES     = 4;
    localparam int MAX_DEPTH = 8;
    localparam int DW        = 4;

    logic                   clk_8f = 1'b0;
    logic                   reset;
    logic [LANES*WIDTH-1:0] data_in;
    logic [LANES-1:0]       valid_in;
    logic [LANES*DW-1:0]    delay_cfg;
    logic                   cfg_load;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic                   busy;
`ifdef RX_DELAY_ALIGN_FLAG_EN
    logic                   aligned;
`endif

    rx_delay_line #(
        .WIDTH     (WIDTH),
        .LANES     (LANES),
        .MAX_DEPTH (MAX_DEPTH),
        .DW        (DW)
    ) dut (
        .clk_8f    (clk_8f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .delay_cfg (delay_cfg),
        .cfg_load  (cfg_load),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy)
`ifdef RX_DELAY_ALIGN_FLAG_EN
        ,
        .aligned   (aligned)
`endif
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        int                  due;
        int                  lane;
        logic [WIDTH-1:0]    data;
    } exp_t;

    typedef struct {
        logic [LANES*DW-1:0] cfg;
        int                  lat [LANES];
    } vec_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   tests = 0;
    int   fails = 0;
    int   e = 0;
    int   busy_until = -1;
    int   busy_hi = 0;
    int   m_d[LANES];
    int   first_seen[LANES];
    int   lat_res[LANES];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, e, act, expv);
        end
    endtask

    function automatic int clampd(input int v);
        if (v == 0) return 1;
        if (v > MAX_DEPTH) return MAX_DEPTH;
        return v;
    endfunction

    function automatic logic [LANES*WIDTH-1:0] rnd_data();
        return (LANES*WIDTH)'($urandom);
    endfunction

    task automatic check_outputs();
        logic [LANES-1:0]       ev;
        logic [LANES*WIDTH-1:0] ed;
        logic                   eb;
        ev = '0;
        ed = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == e) begin
                ev[sb[i].lane] = 1'b1;
                ed[sb[i].lane*WIDTH +: WIDTH] = sb[i].data;
                sb.delete(i);
            end
        end
        eb = (e <= busy_until);
        check("valid_out", 64'(valid_out), 64'(ev));
        check("data_out", 64'(data_out), 64'(ed));
        check("busy", 64'(busy), 64'(eb));
`ifdef RX_DELAY_ALIGN_FLAG_EN
        check("aligned", 64'(aligned), 64'((&ev) && !eb));
`endif
        for (int n = 0; n < LANES; n++) begin
            if (valid_out[n] && first_seen[n] < 0) first_seen[n] = e;
        end
        if (busy) busy_hi++;
    endtask

    // Drive one cycle of stimulus, predict its outputs, then check after the edge.
    task automatic drive_cycle(input logic [LANES-1:0] vin, input logic [LANES*WIDTH-1:0] din,
                               input logic load, input logic [LANES*DW-1:0] cfg);
        int mx;
        valid_in  = vin;
        data_in   = din;
        cfg_load  = load;
        delay_cfg = cfg;
        if (load) begin
            sb.delete();
            mx = 0;
            for (int n = 0; n < LANES; n++) begin
                m_d[n] = clampd(int'(cfg[n*DW +: DW]));
                if (m_d[n] > mx) mx = m_d[n];
            end
            busy_until = e + mx;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (vin[n]) sb.push_back('{due: e + m_d[n], lane: n, data: din[n*WIDTH +: WIDTH]});
            end
        end
        @(posedge clk_8f);
        e++;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle('0, rnd_data(), 1'b0, '0);
    endtask

    task automatic do_reset(input int n, input logic load);
        repeat (n) begin
            reset     = 1'b0;
            valid_in  = '1;
            data_in   = rnd_data();
            cfg_load  = load;
            delay_cfg = {LANES{4'd1}};
            @(posedge clk_8f);
            e++;
            sb.delete();
            for (int k = 0; k < LANES; k++) m_d[k] = MAX_DEPTH;
            busy_until = -1;
            #1;
            check_outputs();
        end
        reset = 1'b1;
    endtask

    task automatic pulse_measure(input logic [LANES-1:0] mask, input logic [LANES*WIDTH-1:0] din);
        int t0;
        for (int n = 0; n < LANES; n++) first_seen[n] = -1;
        t0 = e + 1;
        drive_cycle(mask, din, 1'b0, '0);
        idle(MAX_DEPTH + 4);
        for (int n = 0; n < LANES; n++) begin
            lat_res[n] = (first_seen[n] < 0) ? -1 : first_seen[n] - t0 + 1;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy === 1'b1 && k < 40) begin
            drive_cycle('0, rnd_data(), 1'b0, '0);
            k++;
        end
        check("busy_clears", 64'(busy), 64'(0));
    endtask

    initial begin
        int lb;
        // cfg packs lane3..lane0 MSB first; lat lists lane0..lane3.
        tbl[0].cfg = {4'd8, 4'd3, 4'd15, 4'd0};  tbl[0].lat = '{1, 8, 3, 8};
        tbl[1].cfg = {4'd4, 4'd1, 4'd2, 4'd9};   tbl[1].lat = '{8, 2, 1, 4};
        tbl[2].cfg = {4'd0, 4'd5, 4'd6, 4'd7};   tbl[2].lat = '{7, 6, 5, 1};
        tbl[3].cfg = {4'd12, 4'd2, 4'd8, 4'd10}; tbl[3].lat = '{8, 8, 2, 8};

        reset = 1'b0; cfg_load = 1'b0; valid_in = '0; data_in = '0; delay_cfg = '0;
        for (int n = 0; n < LANES; n++) begin m_d[n] = MAX_DEPTH; first_seen[n] = -1; end

        // Reset with cfg_load high: load must be ignored.
        do_reset(3, 1'b1);

        // Default latency on lane 0 with a single pulse of data 1.
        pulse_measure(4'b0001, {{(LANES-1)*WIDTH{1'b0}}, 4'h1});
        check("lat_default_lane0", 64'(lat_res[0]), 64'(8));

        // Load {1,3,5,8}: busy for 8 cycles, pulse at load+1.
        busy_hi = 0;
        drive_cycle('0, rnd_data(), 1'b1, {4'd8, 4'd5, 4'd3, 4'd1});
        pulse_measure('1, rnd_data());
        check("lat_1358_lane0", 64'(lat_res[0]), 64'(1));
        check("lat_1358_lane1", 64'(lat_res[1]), 64'(3));
        check("lat_1358_lane2", 64'(lat_res[2]), 64'(5));
        check("lat_1358_lane3", 64'(lat_res[3]), 64'(8));
        check("busy_cycles_1358", 64'(busy_hi), 64'(8));

        // Clamp / latency vector table.
        for (int r = 0; r < 4; r++) begin
            drive_cycle('0, rnd_data(), 1'b1, tbl[r].cfg);
            wait_idle();
            pulse_measure('1, rnd_data());
            for (int n = 0; n < LANES; n++) begin
                check($sformatf("tbl%0d_lat_lane%0d", r, n), 64'(lat_res[n]), 64'(tbl[r].lat[n]));
            end
        end

        // Restart during FLUSH under continuous traffic.
        repeat (5) drive_cycle('1, rnd_data(), 1'b0, '0);
        drive_cycle('1, rnd_data(), 1'b1, {4'd2, 4'd4, 4'd6, 4'd8});
        repeat (2) drive_cycle('1, rnd_data(), 1'b0, '0);
        drive_cycle('1, rnd_data(), 1'b1, {4'd4, 4'd3, 4'd2, 4'd1});
        lb = e;
        repeat (8) begin
            drive_cycle('1, rnd_data(), 1'b0, '0);
            if (e == lb + 3) check("restart_busy_hold", 64'(busy), 64'(1));
            if (e == lb + 4) check("restart_busy_fall", 64'(busy), 64'(0));
        end
        idle(MAX_DEPTH);

        // Reset in the middle of a refill with continuous valid input.
        drive_cycle('1, rnd_data(), 1'b1, {4'd3, 4'd3, 4'd3, 4'd3});
        repeat (2) drive_cycle('1, rnd_data(), 1'b0, '0);
        do_reset(1, 1'b1);
        check("reset_abort_busy", 64'(busy), 64'(0));
        pulse_measure('1, rnd_data());
        for (int n = 0; n < LANES; n++) begin
            check($sformatf("lat_after_reset_lane%0d", n), 64'(lat_res[n]), 64'(8));
        end

        // Equal delays of 2, continuous valid, one lane dropping out briefly, then random traffic.
        drive_cycle('0, rnd_data(), 1'b1, {4'd2, 4'd2, 4'd2, 4'd2});
        repeat (6) drive_cycle('1, rnd_data(), 1'b0, '0);
        drive_cycle(4'b1011, rnd_data(), 1'b0, '0);
        repeat (4) drive_cycle('1, rnd_data(), 1'b0, '0);
        repeat (30) drive_cycle(LANES'($urandom), rnd_data(), 1'b0, '0);
        idle(MAX_DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish at edge %0d", e);
        $fatal(1);
    end

endmodule

// File: doc/rx_delay_line.md
RX_DELAY_LINE -- requirements
Module: rx_delay_line

Interface
REQ-001 The block SHALL take parameter WIDTH, default 1, as the bits per lane.
REQ-002 The block SHALL take parameter LANES, default 4, as the number of independent lanes.
REQ-003 The block SHALL take parameter MAX_DEPTH, default 8, as the maximum delay in clocks (range 2..16).
REQ-004 The block SHALL take parameter DW, default 4, as the width of each lane's delay field; DW SHALL satisfy 2**DW > MAX_DEPTH.
REQ-005 The block SHALL have the port clk_8f, input, 1 bit: sole clock, all logic on its rising edge.
REQ-006 The block SHALL have the port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have the port data_in, input, LANES*WIDTH bits: lane n at bits [n*WIDTH +: WIDTH].
REQ-008 The block SHALL have the port valid_in, input, LANES bits: per-lane input qualifier.
REQ-009 The block SHALL have the port delay_cfg, input, LANES*DW bits: per-lane requested delay.
REQ-010 The block SHALL have the port cfg_load, input, 1 bit: single-cycle strobe that latches delay_cfg.
REQ-011 The block SHALL have the port data_out, output, LANES*WIDTH bits: delayed data, registered.
REQ-012 The block SHALL have the port valid_out, output, LANES bits: delayed qualifier, registered.
REQ-013 The block SHALL have the port busy, output, 1 bit: high while the pipeline refills after a load.

Function
REQ-014 Each lane SHALL contain a MAX_DEPTH-stage shift register of {valid, data} that advances every clock; there is no stall.
REQ-015 The active delay D[n] SHALL be the latched delay_cfg field: a value of 0 clamps to 1, and a value above MAX_DEPTH clamps to MAX_DEPTH.
REQ-016 An input valid_in[n]/data_in lane n sampled at edge t SHALL appear on valid_out[n]/data_out lane n after edge t+D[n]-1, visible in cycle t+D[n] (exact latency D[n]).
REQ-017 While valid_out[n]=0, data_out lane n SHALL be 0; no stale data is exposed.
REQ-018 The control FSM SHALL have two states, RUN and FLUSH, and reset SHALL enter RUN with D[n]=MAX_DEPTH for all lanes.
REQ-019 In RUN, cfg_load=1 SHALL latch the clamped delays, clear every stage's valid and data bits in the same edge, load the refill counter with max(D[n]), and go to FLUSH.
REQ-020 In FLUSH, the counter SHALL decrement each clock, and the FSM SHALL return to RUN on the edge where the counter reaches 0; busy SHALL equal (state==FLUSH).
REQ-021 During FLUSH, the shift registers SHALL keep accepting new input; inputs presented in the first FLUSH cycle emerge normally at their new latency.
REQ-022 A cfg_load during FLUSH SHALL re-latch the delays, re-clear the stages, and reload the counter (restart); the FSM SHALL stay in FLUSH.
REQ-023 A cfg_load in the same cycle as reset low SHALL be ignored, because reset has priority.
REQ-024 Lanes SHALL be fully independent apart from the shared FSM and counter.

Reset
REQ-025 While reset=0 at a rising edge, all stages, data_out, valid_out, the counter, and busy SHALL go to 0, the state SHALL go to RUN, and D[n] SHALL go to MAX_DEPTH.
REQ-026 A reset asserted mid-FLUSH SHALL abort the refill; the first cycle after release SHALL show busy=0.

Configuration
REQ-027 When macro RX_DELAY_ALIGN_FLAG_EN is defined, the block SHALL add output aligned (1 bit, registered, reset 0), which is 1 when valid_out is all-ones and busy=0.
REQ-028 When RX_DELAY_ALIGN_FLAG_EN is undefined, the aligned port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold the FSM state typedef (RUN, FLUSH), the default constants for WIDTH, LANES, MAX_DEPTH and DW, and a delay-clamp function.
REQ-030 The per-lane shift register plus tap mux SHALL be the sub-module rx_delay_lane, instantiated LANES times via generate; the FSM and counter SHALL stay in the top.

Verification
REQ-031 Scenario: after reset release with no cfg_load, lane0 valid_in=1 and data_in=1 for one cycle at t=0 -> valid_out[0]=1, data_out=1 exactly in cycle 8, and 0 in all other cycles.
REQ-032 Scenario: cfg_load with delays {1,3,5,8} -> busy=1 for exactly 8 cycles; a single pulse on all lanes at load+1 emerges at +1, +3, +5 and +8 respectively.
REQ-033 Scenario: delay_cfg lane value 0 and lane value 15 (MAX_DEPTH=8) -> measured latencies are 1 and 8.
REQ-034 Scenario: cfg_load at cycle 10, then a second cfg_load at cycle 13 with max delay 4 -> busy stays 1 through cycle 17 and falls at 18; no valid_out from pre-load data appears.
REQ-035 Scenario: reset pulled low mid-FLUSH with continuous valid input -> next cycle all outputs are 0, busy=0, and the default latency of 8 is restored.
REQ-036 Scenario: with RX_DELAY_ALIGN_FLAG_EN defined, delays {2,2,2,2} and continuous valid on all lanes -> aligned=1 from the cycle busy falls; dropping one lane's valid drops aligned two cycles later.
